// File: rtl/seq_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM states and sizing helpers.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-wide slices in a WIDTH-bit operand.
  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Width of the chunk index counter.
  function automatic int cnt_width(input int width, input int chunk);
    return $clog2(width / chunk) + 1;
  endfunction

endpackage

// File: rtl/seq_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder slice; also exposes the carry into its
// top bit so the caller can derive two's-complement overflow.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  // Full-adder cell per bit, carries rippling upward.
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
    assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_adder.sv
// Sequential adder/subtractor: processes CHUNK bits per clock over
// WIDTH/CHUNK cycles using a single chunk_adder slice.
module seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  import seq_adder_pkg::*;

  // Refuse to build with a chunk size that does not tile the operand.
  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
    $error("seq_adder: WIDTH must be a positive multiple of CHUNK");
  end

  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int CW = cnt_width(WIDTH, CHUNK);
  localparam logic [CW-1:0] K_LAST = CW'(N - 1);

  state_t           state_reg;
  state_t           state_next;

  // acc_reg starts as operand A and is shifted right one chunk per cycle while
  // result chunks enter at the top; after N cycles it holds the full result.
  // Sharing the register keeps the flop count near 3*WIDTH.
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [CW-1:0]    k_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic [CHUNK-1:0] s_w;
  logic             co_w;
  logic             c_msb_w;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] b_shift;
  logic             accept;
  logic             last_chunk;

  assign accept     = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_chunk = (state_reg == RUN) && (k_reg == K_LAST);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x     (acc_reg[CHUNK-1:0]),
    .y     (b_reg[CHUNK-1:0]),
    .ci    (carry_reg),
    .s     (s_w),
    .co    (co_w),
    .c_msb (c_msb_w)
  );

  // With a single chunk there is nothing left to shift down.
  if (N == 1) begin : g_single
    assign acc_next = s_w;
    assign b_shift  = '0;
  end else begin : g_multi
    assign acc_next = {s_w, acc_reg[WIDTH-1:CHUNK]};
    assign b_shift  = {{CHUNK{1'b0}}, b_reg[WIDTH-1:CHUNK]};
  end

  // State register; reset wins over any start request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (k_reg == K_LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-chunk accumulation and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      k_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      acc_reg   <= a;
      b_reg     <= sub ? ~b : b;
      carry_reg <= sub ? 1'b1 : cin;
      k_reg     <= '0;
    end else if (state_reg == RUN) begin
      acc_reg   <= acc_next;
      b_reg     <= b_shift;
      carry_reg <= co_w;
      k_reg     <= k_reg + CW'(1);
      if (last_chunk) begin
        sum_reg  <= acc_next;
        cout_reg <= co_w;
        ovf_reg  <= co_w ^ c_msb_w;
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder (WIDTH=16, CHUNK=4): scoreboard queue fed
// at stimulus time, drained by a monitor on every done pulse.
module tb_seq_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_count = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  seq_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Reference: arithmetic on integers, overflow from the signed range.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mcin, input logic msub);
    exp_t r;
    int unsigned ua = ma;
    int unsigned ub = mb;
    int sa = $signed(ma);
    int sb = $signed(mb);
    int sres;
    int unsigned full;
    if (msub) begin
      full   = ua - ub;
      r.sum  = full[15:0];
      r.cout = (ua >= ub);
      sres   = sa - sb;
    end else begin
      full   = ua + ub + (mcin ? 1 : 0);
      r.sum  = full[15:0];
      r.cout = full[16];
      sres   = sa + sb + (mcin ? 1 : 0);
    end
    r.ovf = (sres > 32767) || (sres < -32768);
    return r;
  endfunction

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        mon_e = exp_q.pop_front();
        check("sum", {16'd0, sum}, {16'd0, mon_e.sum});
        check("cout", {31'd0, cout}, {31'd0, mon_e.cout});
        check("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
        $display("[TB] done: sum=%04h cout=%0b ovf=%0b", sum, cout, ovf);
      end
    end
  end

  // One operation from idle; inputs are scrambled while it runs.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tcin, input logic tsub, input exp_t e);
    int done_at;
    int busy_cnt;
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
    exp_q.push_back(e);
    done_at  = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 12 && done_at < 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      if (busy) busy_cnt++;
      if (done) done_at = i;
    end
    check("latency", done_at, 5);
    check("busy_cycles", busy_cnt, 4);
  endtask

  initial begin
    int first_at;
    int second_at;
    int d0;
    logic [15:0] ra;
    logic [15:0] rb;
    logic rc;
    logic rs;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sum", {16'd0, sum}, 0);
    check("rst_cout", {31'd0, cout}, 0);
    check("rst_ovf", {31'd0, ovf}, 0);
    rst = 1'b0;

    // Directed arithmetic cases.
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0});
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1});
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0});
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1});

    // Start and input changes during RUN must be ignored.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    exp_q.push_back('{16'h2345, 1'b0, 1'b0});
    d0 = done_count;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 2 || i == 3) begin
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b1; start = 1'b1;
      end
      if (i == 4) start = 1'b0;
    end
    check("ignore_start_dones", done_count - d0, 1);

    // Back-to-back: start held in the DONE cycle.
    @(negedge clk);
    a = 16'h4000; b = 16'h4000; cin = 1'b0; sub = 1'b0; start = 1'b1;
    exp_q.push_back('{16'h8000, 1'b0, 1'b1});
    first_at  = -1;
    second_at = -1;
    for (int i = 1; i <= 20 && second_at < 0; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done && first_at < 0) begin
        first_at = i;
        a = 16'h0003; b = 16'h0005; cin = 1'b0; sub = 1'b1; start = 1'b1;
        exp_q.push_back('{16'hFFFE, 1'b0, 1'b0});
      end else if (first_at > 0) begin
        if (i == first_at + 1) begin
          start = 1'b0;
          check("b2b_busy", {31'd0, busy}, 1);
        end
        if (done) second_at = i;
        else check("b2b_hold", {16'd0, sum}, 32'h8000);
      end
    end
    check("b2b_first_lat", first_at, 5);
    check("b2b_second_lat", second_at - first_at, 5);

    // Reset in the second RUN cycle aborts the operation.
    @(negedge clk);
    a = 16'h00F0; b = 16'h000F; cin = 1'b0; sub = 1'b0; start = 1'b1;
    exp_q.push_back('{16'h00FF, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    d0 = done_count;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_sum", {16'd0, sum}, 0);
    repeat (8) @(negedge clk);
    check("abort_no_done", done_count - d0, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b0});

    // Randomized operations against the reference model.
    repeat (40) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom);  rs = 1'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
